// File: rtl/maze_cmd_ctrl.sv
// maze_cmd_ctrl: debounces the touch buttons and turns presses into move or
// rotate commands. It tracks the player cell and heading against the maze
// wall maps and hands each accepted command to the renderer over valid/ready.
module maze_cmd_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned START_ROW       = 0,
   parameter int unsigned START_COL       = 0
) (
   input  logic        clk_in,
   input  logic        reset_btn,
   input  logic [3:0]  touch_btn,
   input  logic [29:0] hor_wall,
   input  logic [29:0] ver_wall,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_mode,
   output logic [2:0]  pos_row,
   output logic [2:0]  pos_col,
   output logic [1:0]  dir,
   output logic        blocked,
   output logic [3:0]  btn_state
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] START_R = 3'(START_ROW);
   localparam logic [2:0] START_C = 3'(START_COL);

   localparam logic [1:0] MODE_NONE = 2'b00;
   localparam logic [1:0] MODE_MOVE = 2'b10;
   localparam logic [1:0] MODE_ROT  = 2'b11;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      ISSUE,
      RELEASE
   } state_t;

   typedef enum logic [1:0] {
      REQ_FWD,
      REQ_BWD,
      REQ_ROTL,
      REQ_ROTR
   } req_t;

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       raw_pressed;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       btn_prev;
   logic [3:0]       press_evt;

   state_t state;
   state_t state_nxt;
   req_t   req;
   req_t   req_nxt;

   logic       cmd_valid_nxt;
   logic [1:0] cmd_mode_nxt;
   logic [2:0] pos_row_nxt;
   logic [2:0] pos_col_nxt;
   logic [1:0] dir_nxt;
   logic       blocked_nxt;

   logic [1:0] move_dir;
   logic [3:0] tgt_row;
   logic [3:0] tgt_col;
   logic [4:0] row5;
   logic [4:0] col5;
   logic [4:0] wall_idx;
   logic       wall_bit;
   logic       move_blocked;

   assign raw_pressed = ~sync2;

   // Two-flop synchronizer on the raw active-low pins
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         sync1 <= 4'b0000;
         sync2 <= 4'b0000;
      end else begin
         sync1 <= touch_btn;
         sync2 <= sync1;
      end
   end

   // Per-button stability counter; state flips after enough differing samples
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         btn_state <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (raw_pressed[i] == btn_state[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               btn_state[i] <= ~btn_state[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Registered rising-edge detect of the debounced state
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         btn_prev  <= 4'b0000;
         press_evt <= 4'b0000;
      end else begin
         btn_prev  <= btn_state;
         press_evt <= btn_state & ~btn_prev;
      end
   end

   // Target cell and the wall bit on the edge being crossed
   always_comb begin
      move_dir = (req == REQ_BWD) ? dir + 2'd2 : dir;
      tgt_row  = {1'b0, pos_row};
      tgt_col  = {1'b0, pos_col};
      row5     = {2'b00, pos_row};
      col5     = {2'b00, pos_col};
      wall_idx = 5'd0;
      wall_bit = 1'b0;
      case (move_dir)
         DIR_N: begin
            tgt_row  = {1'b0, pos_row} - 4'd1;
            wall_idx = row5 * 5'd5 + col5;
            wall_bit = hor_wall[wall_idx];
         end
         DIR_S: begin
            tgt_row  = {1'b0, pos_row} + 4'd1;
            wall_idx = (row5 + 5'd1) * 5'd5 + col5;
            wall_bit = hor_wall[wall_idx];
         end
         DIR_W: begin
            tgt_col  = {1'b0, pos_col} - 4'd1;
            wall_idx = row5 * 5'd6 + col5;
            wall_bit = ver_wall[wall_idx];
         end
         DIR_E: begin
            tgt_col  = {1'b0, pos_col} + 4'd1;
            wall_idx = row5 * 5'd6 + col5 + 5'd1;
            wall_bit = ver_wall[wall_idx];
         end
         default: begin
            wall_bit = 1'b1;
         end
      endcase
      move_blocked = wall_bit || (tgt_row > 4'd4) || (tgt_col > 4'd4);
   end

   // Command FSM state and registered outputs
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         state     <= IDLE;
         req       <= REQ_FWD;
         cmd_valid <= 1'b0;
         cmd_mode  <= MODE_NONE;
         pos_row   <= START_R;
         pos_col   <= START_C;
         dir       <= DIR_N;
         blocked   <= 1'b0;
      end else begin
         state     <= state_nxt;
         req       <= req_nxt;
         cmd_valid <= cmd_valid_nxt;
         cmd_mode  <= cmd_mode_nxt;
         pos_row   <= pos_row_nxt;
         pos_col   <= pos_col_nxt;
         dir       <= dir_nxt;
         blocked   <= blocked_nxt;
      end
   end

   // Command FSM next state and next output values
   always_comb begin
      state_nxt     = state;
      req_nxt       = req;
      cmd_valid_nxt = cmd_valid;
      cmd_mode_nxt  = cmd_mode;
      pos_row_nxt   = pos_row;
      pos_col_nxt   = pos_col;
      dir_nxt       = dir;
      blocked_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (|press_evt) begin
               state_nxt = CHECK;
               if (press_evt[0]) begin
                  req_nxt = REQ_FWD;
               end else if (press_evt[1]) begin
                  req_nxt = REQ_BWD;
               end else if (press_evt[2]) begin
                  req_nxt = REQ_ROTL;
               end else begin
                  req_nxt = REQ_ROTR;
               end
            end
         end
         CHECK: begin
            case (req)
               REQ_ROTL: begin
                  dir_nxt       = dir - 2'd1;
                  cmd_mode_nxt  = MODE_ROT;
                  cmd_valid_nxt = 1'b1;
                  state_nxt     = ISSUE;
               end
               REQ_ROTR: begin
                  dir_nxt       = dir + 2'd1;
                  cmd_mode_nxt  = MODE_ROT;
                  cmd_valid_nxt = 1'b1;
                  state_nxt     = ISSUE;
               end
               default: begin
                  if (move_blocked) begin
                     blocked_nxt = 1'b1;
                     state_nxt   = RELEASE;
                  end else begin
                     pos_row_nxt   = tgt_row[2:0];
                     pos_col_nxt   = tgt_col[2:0];
                     cmd_mode_nxt  = MODE_MOVE;
                     cmd_valid_nxt = 1'b1;
                     state_nxt     = ISSUE;
                  end
               end
            endcase
         end
         ISSUE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_valid_nxt = 1'b0;
               cmd_mode_nxt  = MODE_NONE;
               state_nxt     = RELEASE;
            end
         end
         RELEASE: begin
            if (btn_state == 4'b0000) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_maze_cmd_ctrl.sv
// Directed plus randomized bench for maze_cmd_ctrl with a cell/heading model.
module tb_maze_cmd_ctrl;

   logic        clk_in = 1'b0;
   logic        reset_btn;
   logic [3:0]  touch_btn;
   logic [29:0] hor_wall;
   logic [29:0] ver_wall;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [2:0]  pos_row;
   logic [2:0]  pos_col;
   logic [1:0]  dir;
   logic        blocked;
   logic [3:0]  btn_state;

   int vecs    = 0;
   int miscmp  = 0;
   int m_r     = 0;
   int m_c     = 0;
   int m_d     = 0;

   maze_cmd_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .START_ROW(0),
      .START_COL(0)
   ) dut (
      .clk_in   (clk_in),
      .reset_btn(reset_btn),
      .touch_btn(touch_btn),
      .hor_wall (hor_wall),
      .ver_wall (ver_wall),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode (cmd_mode),
      .pos_row  (pos_row),
      .pos_col  (pos_col),
      .dir      (dir),
      .blocked  (blocked),
      .btn_state(btn_state)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Borders always walled; interior either open or random
   task automatic set_walls(input bit rnd);
      logic [29:0] h;
      logic [29:0] v;
      h = '0;
      v = '0;
      for (int r = 0; r <= 5; r++) begin
         for (int c = 0; c <= 4; c++) begin
            if (r == 0 || r == 5) h[5'(r*5+c)] = 1'b1;
            else if (rnd) h[5'(r*5+c)] = 1'($urandom_range(0, 2) == 0);
         end
      end
      for (int r = 0; r <= 4; r++) begin
         for (int c = 0; c <= 5; c++) begin
            if (c == 0 || c == 5) v[5'(r*6+c)] = 1'b1;
            else if (rnd) v[5'(r*6+c)] = 1'($urandom_range(0, 2) == 0);
         end
      end
      hor_wall = h;
      ver_wall = v;
   endtask

   // Move legality from cell geometry: stay inside the 5x5 grid, no wall on the crossed edge
   function automatic bit model_blocked(input int r, input int c, input int d);
      int nr;
      int nc;
      logic [29:0] h;
      logic [29:0] v;
      h  = hor_wall;
      v  = ver_wall;
      nr = r + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
      nc = c + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
      if (nr < 0 || nr > 4 || nc < 0 || nc > 4) return 1'b1;
      case (d)
         0:       return h[5'(r*5+c)];
         2:       return h[5'((r+1)*5+c)];
         3:       return v[5'(r*6+c)];
         default: return v[5'(r*6+c+1)];
      endcase
   endfunction

   // Press the buttons in mask, check the response, hold, then release
   task automatic press(input logic [3:0] mask, input int rdelay);
      int  b;
      int  kind;
      int  nr;
      int  nc;
      int  nd;
      int  md;
      bit  seen;
      bit  ok;
      b = 0;
      for (int i = 3; i >= 0; i--) if (mask[i]) b = i;
      nr = m_r;
      nc = m_c;
      nd = m_d;
      if (b == 2) begin
         kind = 0;
         nd   = (m_d + 3) % 4;
      end else if (b == 3) begin
         kind = 0;
         nd   = (m_d + 1) % 4;
      end else begin
         md = (b == 0) ? m_d : (m_d + 2) % 4;
         if (model_blocked(m_r, m_c, md)) begin
            kind = 2;
         end else begin
            kind = 1;
            nr   = m_r + ((md == 2) ? 1 : 0) - ((md == 0) ? 1 : 0);
            nc   = m_c + ((md == 1) ? 1 : 0) - ((md == 3) ? 1 : 0);
         end
      end
      cmd_ready = (rdelay == 0);
      touch_btn = ~mask;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk_in);
         if (cmd_valid === 1'b1 || blocked === 1'b1) seen = 1'b1;
      end
      chk("response_seen", 32'(seen), 32'd1);
      if (seen) begin
         chk("btn_state_pressed", 32'(btn_state), 32'(mask));
         if (kind == 2) begin
            chk("blocked_pulse", 32'(blocked), 32'd1);
            chk("blocked_no_valid", 32'(cmd_valid), 32'd0);
            chk("blocked_row", 32'(pos_row), 32'(m_r));
            chk("blocked_col", 32'(pos_col), 32'(m_c));
            chk("blocked_dir", 32'(dir), 32'(m_d));
            @(negedge clk_in);
            chk("blocked_one_cycle", 32'(blocked), 32'd0);
         end else begin
            chk("cmd_valid", 32'(cmd_valid), 32'd1);
            chk("cmd_mode", 32'(cmd_mode), (kind == 0) ? 32'd3 : 32'd2);
            chk("pos_row", 32'(pos_row), 32'(nr));
            chk("pos_col", 32'(pos_col), 32'(nc));
            chk("dir", 32'(dir), 32'(nd));
            if (rdelay > 0) begin
               ok = 1'b1;
               repeat (rdelay) begin
                  @(negedge clk_in);
                  if (cmd_valid !== 1'b1 || pos_row !== 3'(nr) || pos_col !== 3'(nc) ||
                      dir !== 2'(nd) || cmd_mode !== ((kind == 0) ? 2'b11 : 2'b10)) ok = 1'b0;
               end
               chk("backpressure_hold", 32'(ok), 32'd1);
               cmd_ready = 1'b1;
            end
            @(negedge clk_in);
            chk("valid_drop", 32'(cmd_valid), 32'd0);
            chk("mode_clear", 32'(cmd_mode), 32'd0);
         end
      end
      m_r = nr;
      m_c = nc;
      m_d = nd;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk_in);
         if (cmd_valid !== 1'b0 || blocked !== 1'b0) ok = 1'b0;
      end
      chk("hold_single_cmd", 32'(ok), 32'd1);
      touch_btn = 4'hF;
      repeat (15) @(negedge clk_in);
      chk("btn_state_released", 32'(btn_state), 32'd0);
      cmd_ready = 1'b1;
   endtask

   initial begin
      bit ok;
      bit seen;
      touch_btn = 4'hF;
      cmd_ready = 1'b1;
      set_walls(1'b0);
      reset_btn = 1'b1;
      repeat (3) @(negedge clk_in);
      reset_btn = 1'b0;
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_mode", 32'(cmd_mode), 32'd0);
      chk("rst_pos_row", 32'(pos_row), 32'd0);
      chk("rst_pos_col", 32'(pos_col), 32'd0);
      chk("rst_dir", 32'(dir), 32'd0);
      chk("rst_blocked", 32'(blocked), 32'd0);
      chk("rst_btn_state", 32'(btn_state), 32'd0);
      repeat (6) @(negedge clk_in);
      chk("post_rst_btn_state", 32'(btn_state), 32'd0);

      // North off the top border, with and without the border wall bit
      press(4'b0001, 0);
      hor_wall[0] = 1'b0;
      press(4'b0001, 0);
      set_walls(1'b0);

      // Rotation wrap, then face south and step forward
      press(4'b0100, 0);
      press(4'b1000, 0);
      press(4'b1000, 0);
      press(4'b1000, 0);
      press(4'b0001, 0);

      // Backpressure for 10 cycles
      press(4'b0001, 10);

      // Three-cycle glitch must not register
      touch_btn = ~4'b0001;
      repeat (3) @(negedge clk_in);
      touch_btn = 4'hF;
      ok = 1'b1;
      repeat (15) begin
         @(negedge clk_in);
         if (btn_state !== 4'b0000 || cmd_valid !== 1'b0 || blocked !== 1'b0) ok = 1'b0;
      end
      chk("glitch_ignored", 32'(ok), 32'd1);

      // Backward and rotate-right together: only backward executes
      press(4'b1010, 0);

      // Randomized presses over random interior walls
      repeat (30) begin
         if ($urandom_range(0, 3) == 0) set_walls(1'b1);
         press(4'($urandom_range(1, 15)), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
      end

      // Asynchronous reset while a command is stalled
      set_walls(1'b0);
      cmd_ready = 1'b0;
      touch_btn = ~4'b1000;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk_in);
         if (cmd_valid === 1'b1) seen = 1'b1;
      end
      chk("rst_test_valid_seen", 32'(seen), 32'd1);
      #2 reset_btn = 1'b1;
      #1;
      chk("async_rst_valid", 32'(cmd_valid), 32'd0);
      chk("async_rst_row", 32'(pos_row), 32'd0);
      chk("async_rst_col", 32'(pos_col), 32'd0);
      chk("async_rst_dir", 32'(dir), 32'd0);
      touch_btn = 4'hF;
      cmd_ready = 1'b1;
      repeat (3) @(negedge clk_in);
      reset_btn = 1'b0;
      m_r = 0;
      m_c = 0;
      m_d = 0;
      repeat (8) @(negedge clk_in);
      chk("after_rst_btn_state", 32'(btn_state), 32'd0);
      press(4'b0001, 0);
      press(4'b1000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
